alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 cmd_valid  input  1  command offered.
REQ-004 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clk edge.
REQ-005 cmd_sel  input  3  opcode, ALU encoding 000 add … 111 b>>3.
REQ-006 cmd_a, cmd_b  input  4 each  operands.
REQ-007 alu_sel  output  3  registered opcode driven to the combinational ALU.
REQ-008 alu_a, alu_b  output  4 each  registered operands driven to the ALU.
REQ-009 alu_y  input  8  ALU result, combinational from alu_a/alu_b/alu_sel.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  result consumed when rsp_valid && rsp_ready at a clk edge.
REQ-012 rsp_y  output  8  captured result.
REQ-013 rsp_sel  output  3  opcode that produced rsp_y.
REQ-014 op_cnt  output  8  count of completed response handshakes.
REQ-015 chk_err  output  1  sticky self-check mismatch flag (see Configuration).

Function
REQ-016 FSM states IDLE, DRIVE, HOLD; encoding free.
REQ-017 cmd_ready SHALL be 1 only in IDLE (not reset-dependent glitch: 0 while rst high).
REQ-018 IDLE: on cmd handshake, register cmd_sel/a/b into alu_sel/a/b, go DRIVE.
REQ-019 DRIVE: one cycle for ALU settle; at next edge capture alu_y into rsp_y, alu_sel into rsp_sel, set rsp_valid, go HOLD.
REQ-020 Latency: rsp_valid high exactly 2 edges after the accepting edge.
REQ-021 HOLD: rsp_valid, rsp_y, rsp_sel, alu_* stable until rsp handshake; then rsp_valid=0, go IDLE.
REQ-022 Throughput 1 command per 3 cycles minimum; cmd_valid in DRIVE/HOLD SHALL be ignored (not accepted).
REQ-023 rsp_ready with rsp_valid=0 SHALL have no effect.
REQ-024 op_cnt SHALL increment by 1 on each rsp handshake, wrapping 255 -> 0.
REQ-025 alu_* outputs retain last command values in IDLE.

Reset
REQ-026 rst SHALL force, asynchronously: state IDLE, alu_sel/alu_a/alu_b=0, rsp_valid=0, rsp_y=0, rsp_sel=0, op_cnt=0, chk_err=0.
REQ-027 Reset during DRIVE or HOLD SHALL abort the command; no response is delivered and op_cnt is not incremented.
REQ-028 First command is acceptable at the first rising edge after rst deasserts.

Configuration
REQ-029 Macro ALU_SEQ_SELFCHK_EN: when defined, block computes expected result from alu_a/alu_b/alu_sel at DRIVE capture and sets chk_err if rsp_y differs; chk_err stays 1 until rst.
REQ-030 Expected model, 8-bit: add/sub/mul on zero-extended operands (sub wraps two's-complement), and/or zero-extended, xnor = ~(a^b) on 8-bit extended operands (upper nibble 1s), not = ~a 8-bit extended, shift = b>>3.
REQ-031 Without ALU_SEQ_SELFCHK_EN, chk_err SHALL be tied 0 and no checker logic synthesised; all other behaviour identical.

Verification
REQ-032 Add: cmd sel=000 a=9 b=8, rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_y=8'h11, rsp_sel=000, op_cnt=1.
REQ-033 Sub/xnor/not: a=2 b=5 sel=001 -> 8'hFD; a=3 b=5 sel=101 -> 8'hF9; a=0 sel=110 -> 8'hFF; chk_err stays 0 with macro defined.
REQ-034 Backpressure: a=15 b=15 sel=010, rsp_ready=0 for 5 cycles -> rsp_y=8'hE1 stable, cmd_ready=0 throughout, second cmd_valid not accepted; released on rsp_ready=1.
REQ-035 Reset in HOLD: accept cmd, assert rst in HOLD -> rsp_valid=0, op_cnt unchanged (0), cmd_ready=1 after release.
REQ-036 Wrap: 256 back-to-back commands -> op_cnt returns to 0; cmd_ready pattern 1-in-3 cycles with rsp_ready=1.
REQ-037 Self-check: force alu_y to 8'h00 for a=1 b=1 sel=000 with macro -> chk_err=1 sticky until rst; without macro chk_err=0.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: command, ALU-drive, response and status signals of alu_seq.
// Handshake rule for both channels (cmd_*, rsp_*): a transfer happens on a
// rising clk edge where valid && ready are both 1. Once raised, valid and its
// payload stay stable until that transfer. A ready seen while valid is low
// means nothing.
interface alu_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_sel;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [7:0] alu_y;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_y;
    logic [2:0] rsp_sel;
    logic [7:0] op_cnt;
    logic       chk_err;

    modport slave (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, alu_y, rsp_ready,
        output cmd_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_y, rsp_sel,
               op_cnt, chk_err
    );

    modport master (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, alu_y, rsp_ready,
        input  cmd_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_y, rsp_sel,
               op_cnt, chk_err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequences one command at a time through an external combinational
// ALU (IDLE -> DRIVE -> HOLD) and returns the captured result.
// Optional feature macro: ALU_SEQ_SELFCHK_EN -- recomputes the expected ALU
// result at capture time and raises a sticky chk_err on any difference.
module alu_seq (
    input  logic        clk,
    input  logic        rst,
    alu_seq_if.slave    bus,
    output logic [1:0]  dbg_state_o
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] alu_sel_q, alu_sel_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_y_q, rsp_y_d;
    logic [2:0] rsp_sel_q, rsp_sel_d;
    logic [7:0] op_cnt_q, op_cnt_d;
    logic       cmd_hs;
    logic       rsp_hs;

    // Ready only in IDLE, and held low while reset is asserted.
    assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
    assign cmd_hs        = bus.cmd_valid && bus.cmd_ready;
    assign rsp_hs        = rsp_valid_q && bus.rsp_ready;

    assign bus.alu_sel   = alu_sel_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_sel   = rsp_sel_q;
    assign bus.op_cnt    = op_cnt_q;
    assign dbg_state_o   = state_q;

    // Next-state and datapath decode for the three-state sequencer.
    always_comb begin
        state_d     = state_q;
        alu_sel_d   = alu_sel_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_sel_d   = rsp_sel_q;
        op_cnt_d    = op_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    alu_sel_d = bus.cmd_sel;
                    alu_a_d   = bus.cmd_a;
                    alu_b_d   = bus.cmd_b;
                    state_d   = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // The ALU has had a full cycle to settle on the registered inputs.
                rsp_y_d     = bus.alu_y;
                rsp_sel_d   = alu_sel_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    op_cnt_d    = op_cnt_q + 8'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_sel_q   <= 3'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= 8'd0;
            rsp_sel_q   <= 3'd0;
            op_cnt_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_sel_q   <= rsp_sel_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

`ifdef ALU_SEQ_SELFCHK_EN
    logic       chk_err_q, chk_err_d;
    logic [7:0] exp_y;

    // Reference result on 8-bit zero-extended operands.
    function automatic logic [7:0] alu_ref(input logic [2:0] sel,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        logic [7:0] a8;
        logic [7:0] b8;
        logic [7:0] r;
        a8 = {4'd0, a};
        b8 = {4'd0, b};
        case (sel)
            3'b000:  r = a8 + b8;
            3'b001:  r = a8 - b8;
            3'b010:  r = a8 * b8;
            3'b011:  r = a8 & b8;
            3'b100:  r = a8 | b8;
            3'b101:  r = ~(a8 ^ b8);
            3'b110:  r = ~a8;
            default: r = b8 >> 3;
        endcase
        return r;
    endfunction

    assign exp_y = alu_ref(alu_sel_q, alu_a_q, alu_b_q);

    // Error latches on a capture whose ALU result disagrees with the reference.
    always_comb begin
        chk_err_d = chk_err_q;
        if ((state_q == ST_DRIVE) && (bus.alu_y != exp_y)) begin
            chk_err_d = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign bus.chk_err = chk_err_q;
`else
    assign bus.chk_err = 1'b0;
`endif
endmodule
